// File: rtl/keypad_passcode.sv
// Keypad passcode lock: collects four BCD digits, compares on ENTER, and times
// an unlock window or an alarm lockout with one shared down-counter.
module keypad_passcode #(
  parameter logic [15:0] PASSCODE       = 16'h1234,
  parameter int unsigned UNLOCK_CYCLES  = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 4000,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic        unlock,
  output logic        alarm,
  output logic        err,
  output logic [1:0]  fail_cnt
);

  localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0] NO_KEY = 4'hf;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       key_prev;
  logic [CNT_W-1:0] cnt;

  logic       press;
  logic       is_digit;
  logic       is_clear;
  logic       is_enter;
  logic [3:0] digit_val;
  logic       fail_last;
  logic       code_ok;

  // Edge-detect a new key and decode it; held keys never re-trigger.
  always_comb begin
    press     = (key_code != NO_KEY) && (key_prev == NO_KEY);
    is_digit  = 1'b0;
    is_clear  = 1'b0;
    is_enter  = 1'b0;
    digit_val = 4'd0;
    unique case (key_code)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        is_digit  = 1'b1;
        digit_val = key_code;
      end
      4'hb:    is_digit = 1'b1;
      4'ha:    is_clear = 1'b1;
      4'hc:    is_enter = 1'b1;
      default: ;
    endcase
    fail_last = (32'({30'd0, fail_cnt}) + 32'd1) >= MAX_FAIL;
    code_ok   = (digit_cnt == 3'd4) && (digits == PASSCODE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ENTRY;
      key_prev  <= NO_KEY;
      cnt       <= '0;
      digits    <= 16'd0;
      digit_cnt <= 3'd0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      err       <= 1'b0;
      fail_cnt  <= 2'd0;
    end else begin
      key_prev <= key_code;
      err      <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (press) begin
            if (is_digit && (digit_cnt < 3'd4)) begin
              digits    <= {digits[11:0], digit_val};
              digit_cnt <= digit_cnt + 3'd1;
            end else if (is_clear) begin
              digits    <= 16'd0;
              digit_cnt <= 3'd0;
            end else if (is_enter) begin
              digits    <= 16'd0;
              digit_cnt <= 3'd0;
              if (code_ok) begin
                state    <= UNLOCKED;
                unlock   <= 1'b1;
                fail_cnt <= 2'd0;
                cnt      <= UNLOCK_LOAD;
              end else begin
                err <= 1'b1;
                if (fail_last) begin
                  state    <= LOCKOUT;
                  alarm    <= 1'b1;
                  fail_cnt <= 2'd0;
                  cnt      <= LOCKOUT_LOAD;
                end else begin
                  fail_cnt <= fail_cnt + 2'd1;
                end
              end
            end
          end
        end
        UNLOCKED: begin
          // CLEAR relocks early; every other key is ignored while open.
          if ((cnt == '0) || (press && is_clear)) begin
            state     <= ENTRY;
            unlock    <= 1'b0;
            cnt       <= '0;
            digits    <= 16'd0;
            digit_cnt <= 3'd0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOCKOUT: begin
          if (cnt == '0) begin
            state     <= ENTRY;
            alarm     <= 1'b0;
            digits    <= 16'd0;
            digit_cnt <= 3'd0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= ENTRY;
          unlock <= 1'b0;
          alarm  <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_passcode.sv
// Scoreboard bench for keypad_passcode: stimulus queues every expected output
// change (plus how long the previous value must have lasted); a monitor pops on each change.
module tb_keypad_passcode;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [3:0]  key_code = 4'hf;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        unlock;
  logic        alarm;
  logic        err;
  logic [1:0]  fail_cnt;

  keypad_passcode dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_code  (key_code),
    .digits    (digits),
    .digit_cnt (digit_cnt),
    .unlock    (unlock),
    .alarm     (alarm),
    .err       (err),
    .fail_cnt  (fail_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  logic [23:0] exp_v[$];
  int          exp_len[$];
  string       exp_tag[$];

  logic [23:0] obs;
  assign obs = {digits, digit_cnt, unlock, alarm, err, fail_cnt};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, want);
    end
  endtask

  function automatic logic [23:0] mk(input logic [15:0] d, input logic [2:0] c, input logic u,
                                     input logic a, input logic e, input logic [1:0] f);
    return {d, c, u, a, e, f};
  endfunction

  // len: required run length (negedges) of the value being replaced; 0 = don't care.
  task automatic push(input string tag, input logic [15:0] d, input logic [2:0] c, input logic u,
                      input logic a, input logic e, input logic [1:0] f, input int len);
    exp_v.push_back(mk(d, c, u, a, e, f));
    exp_len.push_back(len);
    exp_tag.push_back(tag);
  endtask

  task automatic press(input logic [3:0] k);
    key_code = k;
    @(posedge sys_clk); #1;
    key_code = 4'hf;
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every observed change of the output vector consumes one expectation.
  logic [23:0] prev = 24'd0;
  int          run = 0;
  logic [23:0] m_ev;
  int          m_el;
  string       m_et;

  always @(negedge sys_clk) begin
    if (obs !== prev) begin
      if (exp_v.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: got %h expected no change from %h", obs, prev);
      end else begin
        m_ev = exp_v.pop_front();
        m_el = exp_len.pop_front();
        m_et = exp_tag.pop_front();
        check(m_et, 32'(obs), 32'(m_ev));
        if (m_el != 0) check({m_et, "_len"}, 32'(run), 32'(m_el));
      end
      prev = obs;
      run  = 1;
    end else begin
      run++;
    end
  end

  logic [3:0]  t2_keys [4];
  logic [15:0] t2_dig  [4];

  initial begin
    t2_keys = '{4'h1, 4'h2, 4'h3, 4'h5};
    t2_dig  = '{16'h0001, 16'h0012, 16'h0123, 16'h1235};

    #2 sys_rst_n = 1'b0;
    #1 check("reset_state", 32'(obs), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Correct code unlocks for 1000 cycles.
    push("t1_d1", 16'h0001, 3'd1, 0, 0, 0, 2'd0, 0); press(4'h1);
    push("t1_d2", 16'h0012, 3'd2, 0, 0, 0, 2'd0, 0); press(4'h2);
    push("t1_d3", 16'h0123, 3'd3, 0, 0, 0, 2'd0, 0); press(4'h3);
    push("t1_d4", 16'h1234, 3'd4, 0, 0, 0, 2'd0, 0); press(4'h4);
    push("t1_unlock", 16'h0, 3'd0, 1, 0, 0, 2'd0, 0); press(4'hc);
    push("t1_relock", 16'h0, 3'd0, 0, 0, 0, 2'd0, 1000);
    wait_cyc(1010);

    // Three wrong codes: err pulses, fail_cnt 1 then 2, then lockout.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        push("t2_digit", t2_dig[i], 3'(i + 1), 0, 0, 0, 2'(r), 0);
        press(t2_keys[i]);
      end
      if (r < 2) begin
        push("t2_err", 16'h0, 3'd0, 0, 0, 1, 2'(r + 1), 0);
        push("t2_err_end", 16'h0, 3'd0, 0, 0, 0, 2'(r + 1), 1);
        press(4'hc);
      end else begin
        push("t2_lockout", 16'h0, 3'd0, 0, 1, 1, 2'd0, 0);
        push("t2_err_end", 16'h0, 3'd0, 0, 1, 0, 2'd0, 1);
        press(4'hc);
        press(4'h7);
        press(4'h8);
        // err shares the first alarm cycle, so the alarm-only run is 3999.
        push("t2_alarm_end", 16'h0, 3'd0, 0, 0, 0, 2'd0, 3999);
        wait_cyc(4010);
      end
    end

    // Fifth digit ignored when buffer full; CLEAR empties it.
    push("t3_d1", 16'h0009, 3'd1, 0, 0, 0, 2'd0, 0); press(4'h9);
    push("t3_d2", 16'h0099, 3'd2, 0, 0, 0, 2'd0, 0); press(4'h9);
    push("t3_d3", 16'h0999, 3'd3, 0, 0, 0, 2'd0, 0); press(4'h9);
    push("t3_d4", 16'h9999, 3'd4, 0, 0, 0, 2'd0, 0); press(4'h9);
    press(4'h9);
    push("t3_clear", 16'h0, 3'd0, 0, 0, 0, 2'd0, 0); press(4'ha);

    // Held key enters once; codes 0, d, e do nothing; b is digit 0.
    push("t4_hold", 16'h0005, 3'd1, 0, 0, 0, 2'd0, 0);
    key_code = 4'h5;
    wait_cyc(50);
    key_code = 4'hf;
    wait_cyc(1);
    press(4'h0);
    press(4'hd);
    press(4'he);
    push("t4_zero", 16'h0050, 3'd2, 0, 0, 0, 2'd0, 0); press(4'hb);
    push("t4_clear", 16'h0, 3'd0, 0, 0, 0, 2'd0, 0); press(4'ha);

    // CLEAR at cycle 10 of UNLOCKED relocks on the next edge.
    push("t5_d1", 16'h0001, 3'd1, 0, 0, 0, 2'd0, 0); press(4'h1);
    push("t5_d2", 16'h0012, 3'd2, 0, 0, 0, 2'd0, 0); press(4'h2);
    push("t5_d3", 16'h0123, 3'd3, 0, 0, 0, 2'd0, 0); press(4'h3);
    push("t5_d4", 16'h1234, 3'd4, 0, 0, 0, 2'd0, 0); press(4'h4);
    push("t5_unlock", 16'h0, 3'd0, 1, 0, 0, 2'd0, 0); press(4'hc);
    wait_cyc(8);
    push("t5_clear_relock", 16'h0, 3'd0, 0, 0, 0, 2'd0, 10); press(4'ha);
    push("t5_entry_digit", 16'h0001, 3'd1, 0, 0, 0, 2'd0, 0); press(4'h1);
    push("t5_entry_clear", 16'h0, 3'd0, 0, 0, 0, 2'd0, 0); press(4'ha);

    // Short entries into lockout, then asynchronous reset mid-lockout.
    push("t6_err1", 16'h0, 3'd0, 0, 0, 1, 2'd1, 0);
    push("t6_err1_end", 16'h0, 3'd0, 0, 0, 0, 2'd1, 1); press(4'hc);
    push("t6_err2", 16'h0, 3'd0, 0, 0, 1, 2'd2, 0);
    push("t6_err2_end", 16'h0, 3'd0, 0, 0, 0, 2'd2, 1); press(4'hc);
    push("t6_lockout", 16'h0, 3'd0, 0, 1, 1, 2'd0, 0);
    push("t6_err3_end", 16'h0, 3'd0, 0, 1, 0, 2'd0, 1); press(4'hc);
    wait_cyc(100);
    check("t6_alarm_before_rst", 32'(alarm), 32'd1);
    push("t6_rst", 16'h0, 3'd0, 0, 0, 0, 2'd0, 0);
    #1 sys_rst_n = 1'b0;
    #1 check("t6_async_alarm_drop", 32'(obs), 32'd0);
    wait_cyc(3);
    sys_rst_n = 1'b1;
    push("t6_d1", 16'h0001, 3'd1, 0, 0, 0, 2'd0, 0); press(4'h1);
    push("t6_d2", 16'h0012, 3'd2, 0, 0, 0, 2'd0, 0); press(4'h2);
    push("t6_d3", 16'h0123, 3'd3, 0, 0, 0, 2'd0, 0); press(4'h3);
    push("t6_d4", 16'h1234, 3'd4, 0, 0, 0, 2'd0, 0); press(4'h4);
    push("t6_unlock", 16'h0, 3'd0, 1, 0, 0, 2'd0, 0); press(4'hc);
    push("t6_relock", 16'h0, 3'd0, 0, 0, 0, 2'd0, 1000);
    wait_cyc(1010);

    wait_cyc(5);
    check("queue_drained", 32'(exp_v.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
